// File: rtl/onewire_pkg.sv
// Shared types and constants for the 1-Wire master: FSM states, slot/reset timing in microseconds,
// and the register map.
package onewire_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST_LOW,
    ST_RST_WAIT,
    ST_RST_REC,
    ST_SLOT_LOW,
    ST_SLOT_HIGH
  } state_e;

  localparam int US_W   = 10;
  localparam int ADDR_W = 3;

  localparam int T_RST_LOW_US  = 480;
  localparam int T_PRESENCE_US = 70;
  localparam int T_RST_REC_US  = 410;
  localparam int T_W1_LOW_US   = 6;
  localparam int T_W0_LOW_US   = 60;
  localparam int T_SAMPLE_US   = 15;
  localparam int T_SLOT_US     = 70;

  localparam logic [ADDR_W-1:0] ADDR_DATA = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_CTRL = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQ  = 3'd2;

  // A 1-bit (and every read slot) releases early; a 0-bit holds the bus for most of the slot.
  function automatic logic [US_W-1:0] slot_low_us(input logic bit_val);
    return bit_val ? US_W'(T_W1_LOW_US) : US_W'(T_W0_LOW_US);
  endfunction

endpackage

// File: rtl/onewire_if.sv
// Host register bus of the 1-Wire master; the host side uses "master", the peripheral uses "slave".
interface onewire_if;
  import onewire_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [7:0]        writedata;
  logic [7:0]        readdata;

  modport master (output address, chipselect, write_n, writedata, input readdata);
  modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/onewire_tick.sv
// Free-running microsecond prescaler: a one-cycle tick every CLK_FREQ_HZ/1e6 clocks.
module onewire_tick #(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int DIV = CLK_FREQ_HZ / 1000000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/onewire_master.sv
// 1-Wire bus master with reset/presence and byte-wide write/read slots behind a small register bus.
// Optional interrupt output and enable register built when ONEWIRE_IRQ_EN is defined.
module onewire_master
  import onewire_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000
) (
  input  logic      clk,
  input  logic      reset_n,
  onewire_if.slave  bus,
  inout  wire       bidir_port
`ifdef ONEWIRE_IRQ_EN
  ,
  output logic      irq
`endif
);

  state_e            state_q, state_d;
  logic [US_W-1:0]   us_q, us_d, limit;
  logic [1:0]        sync_q, sync_d;
  logic [7:0]        tx_q, tx_d, rx_q, rx_d, rdata_q, rdata_d;
  logic [2:0]        idx_q, idx_d;
  logic              presence_q, presence_d, irq_pend_q, irq_pend_d;
  logic              tick, bus_sync, busy, wr, start_rst, start_tx, cur_bit;
  logic              state_done, sample_pt, xfer_done, drive_low;
`ifdef ONEWIRE_IRQ_EN
  logic              irq_en_q, irq_en_d;
`endif

  onewire_tick #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_tick (
    .clk   (clk),
    .rst_n (reset_n),
    .tick  (tick)
  );

  assign bus_sync  = sync_q[1];
  assign busy      = (state_q != ST_IDLE);
  assign wr        = bus.chipselect & ~bus.write_n;
  assign start_rst = wr && (bus.address == ADDR_CTRL) && bus.writedata[0] && !busy;
  assign start_tx  = wr && (bus.address == ADDR_DATA) && !busy;
  assign cur_bit   = tx_q[idx_q];

  always_comb begin
    limit = '0;
    case (state_q)
      ST_RST_LOW:   limit = US_W'(T_RST_LOW_US);
      ST_RST_WAIT:  limit = US_W'(T_PRESENCE_US);
      ST_RST_REC:   limit = US_W'(T_RST_REC_US);
      ST_SLOT_LOW:  limit = slot_low_us(cur_bit);
      ST_SLOT_HIGH: limit = US_W'(T_SLOT_US) - slot_low_us(cur_bit);
      default:      limit = '0;
    endcase
  end

  // Phases end on the tick that completes the limit, so every phase after the first is tick-aligned.
  assign state_done = busy && tick && (us_q == limit - 1'b1);
  assign sample_pt  = (state_q == ST_SLOT_HIGH) && tick &&
                      (us_q == US_W'(T_SAMPLE_US - T_W1_LOW_US - 1));
  assign xfer_done  = state_done &&
                      ((state_q == ST_RST_REC) || ((state_q == ST_SLOT_HIGH) && (idx_q == 3'd7)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_rst)     state_d = ST_RST_LOW;
        else if (start_tx) state_d = ST_SLOT_LOW;
      end
      ST_RST_LOW:   if (state_done) state_d = ST_RST_WAIT;
      ST_RST_WAIT:  if (state_done) state_d = ST_RST_REC;
      ST_RST_REC:   if (state_done) state_d = ST_IDLE;
      ST_SLOT_LOW:  if (state_done) state_d = ST_SLOT_HIGH;
      ST_SLOT_HIGH: if (state_done) state_d = (idx_q == 3'd7) ? ST_IDLE : ST_SLOT_LOW;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drive_low = (state_q == ST_RST_LOW) || (state_q == ST_SLOT_LOW);
  end

  // Open drain: only ever pull low or release.
  assign bidir_port = drive_low ? 1'b0 : 1'bz;

  always_comb begin
    us_d       = us_q;
    sync_d     = {sync_q[0], bidir_port};
    tx_d       = tx_q;
    rx_d       = rx_q;
    idx_d      = idx_q;
    presence_d = presence_q;
    irq_pend_d = irq_pend_q;
`ifdef ONEWIRE_IRQ_EN
    irq_en_d   = irq_en_q;
`endif

    if (state_d != state_q)  us_d = '0;
    else if (busy && tick)   us_d = us_q + 1'b1;

    if (start_tx) begin
      tx_d  = bus.writedata;
      idx_d = 3'd0;
    end else if ((state_q == ST_SLOT_HIGH) && state_done && (idx_q != 3'd7)) begin
      idx_d = idx_q + 1'b1;
    end

    if (sample_pt) rx_d[idx_q] = cur_bit & bus_sync;

    if (start_rst) presence_d = 1'b0;
    else if ((state_q == ST_RST_WAIT) && state_done) presence_d = ~bus_sync;

    if (wr && (bus.address == ADDR_IRQ)) begin
      if (bus.writedata[1]) irq_pend_d = 1'b0;
`ifdef ONEWIRE_IRQ_EN
      irq_en_d = bus.writedata[0];
`endif
    end
    if (xfer_done) irq_pend_d = 1'b1;

    case (bus.address)
      ADDR_DATA: rdata_d = rx_q;
      ADDR_CTRL: rdata_d = {5'b0, irq_pend_q, presence_q, busy};
`ifdef ONEWIRE_IRQ_EN
      ADDR_IRQ:  rdata_d = {7'b0, irq_en_q};
`endif
      default:   rdata_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      us_q       <= '0;
      sync_q     <= 2'b11;
      tx_q       <= '0;
      rx_q       <= '0;
      idx_q      <= '0;
      presence_q <= 1'b0;
      irq_pend_q <= 1'b0;
      rdata_q    <= '0;
`ifdef ONEWIRE_IRQ_EN
      irq_en_q   <= 1'b0;
`endif
    end else begin
      us_q       <= us_d;
      sync_q     <= sync_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      idx_q      <= idx_d;
      presence_q <= presence_d;
      irq_pend_q <= irq_pend_d;
      rdata_q    <= rdata_d;
`ifdef ONEWIRE_IRQ_EN
      irq_en_q   <= irq_en_d;
`endif
    end
  end

  assign bus.readdata = rdata_q;
`ifdef ONEWIRE_IRQ_EN
  assign irq = irq_pend_q & irq_en_q;
`endif

endmodule

// File: tb/tb_onewire_master.sv
// Directed bench for onewire_master: register-access vector table plus timed bus sequences
// (reset/presence, write slots, read slots with a pulling slave, busy lockout, irq, abort by reset).
module tb_onewire_master;

  localparam int CLK_HZ = 4000000;
  localparam int CPU    = CLK_HZ / 1000000;

  logic clk = 1'b0;
  logic reset_n;
  logic model_low;
  wire  ow_bus;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign ow_bus = model_low ? 1'b0 : 1'bz;
  pullup (ow_bus);

  onewire_if bus_if ();

`ifdef ONEWIRE_IRQ_EN
  wire irq;
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  onewire_master #(.CLK_FREQ_HZ(CLK_HZ)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus_if),
    .bidir_port (ow_bus)
`ifdef ONEWIRE_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  typedef struct {
    bit         do_wr;
    bit         cs;
    bit         wn;
    logic [2:0] waddr;
    logic [7:0] wdata;
    logic [2:0] raddr;
    logic [7:0] exp;
  } vec_t;

  function automatic vec_t mk(bit w, bit cs, bit wn, logic [2:0] wa, logic [7:0] wd,
                              logic [2:0] ra, logic [7:0] e);
    vec_t v;
    v.do_wr = w; v.cs = cs; v.wn = wn; v.waddr = wa; v.wdata = wd; v.raddr = ra; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_bus(input logic lvl, input int bound, input string name);
    int n = 0;
    while (ow_bus !== lvl && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (ow_bus !== lvl) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: bus=%b after %0d cycles, expected %b", name, ow_bus, bound, lvl);
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    bus_if.address = 3'd1;
    @(negedge clk);
    while (bus_if.readdata[0] !== 1'b0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (bus_if.readdata[0] !== 1'b0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: busy=%b after %0d cycles, expected 0", name, bus_if.readdata[0], bound);
    end
  endtask

  task automatic measure_low(input string name, output int start, output int len);
    wait_bus(1'b0, 2000, name);
    start = cyc;
    wait_bus(1'b1, 2200, name);
    len = cyc - start;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.address = a; bus_if.chipselect = 1'b1; bus_if.write_n = 1'b0; bus_if.writedata = d;
    @(negedge clk);
    bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.address = 3'd1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.address = a;
    @(negedge clk);
    d = bus_if.readdata;
  endtask

  // Transfer of pat with no slave response: per-slot low time and slot period; optional busy-time writes.
  task automatic check_slots(input logic [7:0] pat, input string tag, input bit poke);
    int st, len, prev, us;
    prev = 0;
    for (int s = 0; s < 8; s++) begin
      measure_low($sformatf("%s_slot%0d", tag, s), st, len);
      us = pat[s] ? 6 : 60;
      chk_rng($sformatf("%s_low%0d", tag, s), len, us * CPU - (CPU - 1), us * CPU);
      if (s > 0) chk_rng($sformatf("%s_period%0d", tag, s), st - prev, 70 * CPU - (CPU - 1), 70 * CPU);
      prev = st;
      if (poke && s == 1) begin
        repeat (80) @(negedge clk);
        bus_write(3'd0, 8'h3C);
        bus_write(3'd1, 8'h01);
      end
    end
  endtask

  initial begin
    #(600000 * 10);
    $display("FAIL watchdog: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  vec_t       vecs[11];
  logic [7:0] rd;
  logic [7:0] irq_rd;
  int         st, len, t0, lows;

  initial begin
    bus_if.address = 3'd0; bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1; bus_if.writedata = 8'h00;
    model_low = 1'b0;
    reset_n   = 1'b1;
    #2 reset_n = 1'b0;
    irq_rd = IRQ_BUILD ? 8'h01 : 8'h00;

    vecs[0]  = mk(0, 0, 1, 3'd0, 8'h00, 3'd0, 8'h00);
    vecs[1]  = mk(0, 0, 1, 3'd0, 8'h00, 3'd1, 8'h00);
    vecs[2]  = mk(0, 0, 1, 3'd0, 8'h00, 3'd2, 8'h00);
    vecs[3]  = mk(0, 0, 1, 3'd0, 8'h00, 3'd5, 8'h00);
    vecs[4]  = mk(1, 1, 0, 3'd2, 8'h01, 3'd2, irq_rd);
    vecs[5]  = mk(1, 1, 0, 3'd2, 8'h00, 3'd2, 8'h00);
    vecs[6]  = mk(1, 1, 0, 3'd1, 8'hFE, 3'd1, 8'h00);
    vecs[7]  = mk(1, 0, 0, 3'd0, 8'h55, 3'd1, 8'h00);
    vecs[8]  = mk(1, 1, 1, 3'd1, 8'h01, 3'd1, 8'h00);
    vecs[9]  = mk(1, 1, 0, 3'd3, 8'hFF, 3'd3, 8'h00);
    vecs[10] = mk(0, 0, 1, 3'd0, 8'h00, 3'd7, 8'h00);

    repeat (3) @(negedge clk);
    chk("reset_bus_released", ow_bus, 1);
    chk("reset_readdata", bus_if.readdata, 8'h00);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr) begin
        @(negedge clk);
        bus_if.address = vecs[i].waddr; bus_if.chipselect = vecs[i].cs;
        bus_if.write_n = vecs[i].wn;    bus_if.writedata  = vecs[i].wdata;
        @(negedge clk);
        bus_if.chipselect = 1'b0; bus_if.write_n = 1'b1;
      end
      bus_read(vecs[i].raddr, rd);
      chk($sformatf("vec%0d", i), rd, vecs[i].exp);
    end
    chk("idle_bus_high", ow_bus, 1);

    // Reset pulse with a slave answering presence from 15 to 120 us after release.
    bus_write(3'd1, 8'h01);
    measure_low("rst_low", st, len);
    chk_rng("rst_low_len", len, 480 * CPU - (CPU - 1), 480 * CPU);
    chk("status_during_reset", bus_if.readdata, 8'h01);
    repeat (15 * CPU - 1) @(negedge clk);
    model_low = 1'b1;
    repeat (105 * CPU) @(negedge clk);
    model_low = 1'b0;
    wait_idle(5000, "presence_done");
    chk("status_presence", bus_if.readdata, 8'h06);

    // Clear irq_pend, then a reset pulse with no response.
    bus_write(3'd2, 8'h02);
    bus_read(3'd1, rd);
    chk("status_after_clear", rd, 8'h02);
    bus_write(3'd1, 8'h01);
    @(negedge clk);
    t0 = cyc;
    chk("presence_cleared_on_start", bus_if.readdata, 8'h01);
    wait_idle(5000, "noresp_done");
    chk_rng("noresp_busy_cycles", cyc - t0, 959 * CPU, 961 * CPU);
    chk("status_no_presence", bus_if.readdata, 8'h04);

    // Write 0xA5.
    bus_write(3'd0, 8'hA5);
    check_slots(8'hA5, "a5", 1'b0);
    wait_idle(2000, "a5_done");
    bus_read(3'd0, rd);
    chk("a5_rx", rd, 8'hA5);
    bus_read(3'd1, rd);
    chk("a5_status", rd, 8'h04);

    // Read slots with the slave pulling bits 1 and 3 low for 30 us.
    bus_write(3'd0, 8'hFF);
    for (int s = 0; s < 8; s++) begin
      wait_bus(1'b0, 2000, $sformatf("ff_fall%0d", s));
      if (s == 1 || s == 3) begin
        model_low = 1'b1;
        repeat (30 * CPU) @(negedge clk);
        model_low = 1'b0;
        @(negedge clk);
      end else begin
        wait_bus(1'b1, 2000, $sformatf("ff_rise%0d", s));
      end
    end
    wait_idle(2000, "ff_done");
    bus_read(3'd0, rd);
    chk("read_slots_rx", rd, 8'hF5);

    // Writes to DATA and CTRL during a transfer are ignored.
    bus_write(3'd0, 8'h5A);
    check_slots(8'h5A, "5a", 1'b1);
    wait_idle(2000, "5a_done");
    bus_read(3'd0, rd);
    chk("busy_write_ignored_rx", rd, 8'h5A);
    bus_read(3'd1, rd);
    chk("busy_write_ignored_status", rd, 8'h04);

`ifdef ONEWIRE_IRQ_EN
    bus_write(3'd2, 8'h02);
    chk("irq_cleared", irq, 0);
    bus_write(3'd2, 8'h01);
    chk("irq_enabled_no_pend", irq, 0);
    bus_write(3'd0, 8'hFF);
    wait_idle(3000, "irq_xfer_done");
    chk("irq_after_completion", irq, 1);
    bus_write(3'd2, 8'h03);
    chk("irq_after_ack", irq, 0);
    bus_read(3'd2, rd);
    chk("irq_en_readback", rd, 8'h01);
`endif

    // Abort a 0-bit slot 30 us into its low phase with reset.
    bus_write(3'd0, 8'h00);
    wait_bus(1'b0, 100, "abort_fall");
    repeat (30 * CPU) @(negedge clk);
    chk("abort_bus_low_before", ow_bus, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_bus_released", ow_bus, 1);
    chk("abort_readdata", bus_if.readdata, 8'h00);
`ifdef ONEWIRE_IRQ_EN
    chk("abort_irq", irq, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (ow_bus === 1'b0) lows++;
    end
    chk("abort_no_bus_activity", lows, 0);
    bus_read(3'd1, rd);
    chk("abort_status", rd, 8'h00);
    bus_read(3'd0, rd);
    chk("abort_rx", rd, 8'h00);
    bus_read(3'd2, rd);
    chk("abort_irq_reg", rd, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
